// File: rtl/music_seq_ctrl.sv
// music_seq_ctrl: song ROM playback sequencer driving a square-wave buzzer.
// Ports: clk, rst (async high); start_i/stop_i/loop_en_i user controls;
//   rom_addr_o/rom_en_o/rom_data_i song ROM (1-cycle read latency);
//   buzzer_o audio; playing_o busy flag; done_o end-of-song pulse.
module music_seq_ctrl #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int TICK_DIV   = 1_000_000,
  parameter int GAP_TICKS  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  loop_en_i,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  output logic                  rom_en_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  output logic                  buzzer_o,
  output logic                  playing_o,
  output logic                  done_o
);

  localparam int PW = $clog2(TICK_DIV);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_PLAY,
    S_GAP,
    S_END
  } state_t;

  state_t state, state_n;

  logic [ADDR_WIDTH-1:0] addr;
  logic [15:0]           half;
  logic [15:0]           ticks;
  logic [15:0]           tone;
  logic [PW-1:0]         presc;
  logic                  buzz;

  logic addr_clr, addr_inc;
  logic note_load, gap_load;
  logic adv, wrap_req;

  logic end_mark, dur_zero;
  logic tick_wrap, last_tick;
  logic at_max, tone_edge;

  assign end_mark  = (rom_data_i == {DATA_WIDTH{1'b1}});
  assign dur_zero  = (rom_data_i[15:0] == 16'd0);
  assign tick_wrap = (presc == PW'(TICK_DIV - 1));
  assign last_tick = tick_wrap && (ticks == 16'd1);
  assign at_max    = (addr == {ADDR_WIDTH{1'b1}});
  assign tone_edge = (half != 16'd0) && (tone == half - 16'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    addr_clr  = 1'b0;
    addr_inc  = 1'b0;
    note_load = 1'b0;
    gap_load  = 1'b0;
    adv       = 1'b0;
    wrap_req  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start_i && !stop_i) begin
          addr_clr = 1'b1;
          state_n  = S_FETCH;
        end
      end
      S_FETCH: state_n = S_DECODE;
      S_DECODE: begin
        if (end_mark) begin
          wrap_req = 1'b1;
        end else if (dur_zero) begin
          adv = 1'b1;
        end else begin
          note_load = 1'b1;
          state_n   = S_PLAY;
        end
      end
      S_PLAY: begin
        if (last_tick) begin
          if (GAP_TICKS == 0) begin
            adv = 1'b1;
          end else begin
            gap_load = 1'b1;
            state_n  = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (last_tick) adv = 1'b1;
      end
      S_END: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    // Advancing past the last ROM address behaves like an end marker.
    if (adv) begin
      if (at_max) begin
        wrap_req = 1'b1;
      end else begin
        addr_inc = 1'b1;
        state_n  = S_FETCH;
      end
    end
    if (wrap_req) begin
      if (loop_en_i) begin
        addr_clr = 1'b1;
        state_n  = S_FETCH;
      end else begin
        state_n = S_END;
      end
    end
    if (stop_i && state != S_IDLE) begin
      state_n   = S_IDLE;
      addr_clr  = 1'b0;
      addr_inc  = 1'b0;
      note_load = 1'b0;
      gap_load  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr  <= '0;
      half  <= '0;
      ticks <= '0;
      tone  <= '0;
      presc <= '0;
      buzz  <= 1'b0;
    end else begin
      if (addr_clr)      addr <= '0;
      else if (addr_inc) addr <= addr + ADDR_WIDTH'(1);

      // PLAY and GAP share the prescaler and tick counter.
      if (note_load) begin
        half  <= rom_data_i[31:16];
        ticks <= rom_data_i[15:0];
        presc <= '0;
      end else if (gap_load) begin
        ticks <= 16'(GAP_TICKS);
        presc <= '0;
      end else if (state == S_PLAY || state == S_GAP) begin
        if (tick_wrap) begin
          presc <= '0;
          ticks <= ticks - 16'd1;
        end else begin
          presc <= presc + PW'(1);
        end
      end

      if (note_load) begin
        tone <= '0;
      end else if (state == S_PLAY && half != 16'd0) begin
        if (tone_edge) tone <= '0;
        else           tone <= tone + 16'd1;
      end

      // Buzzer is silent in every state but PLAY, including on stop.
      if (state_n != S_PLAY || note_load) buzz <= 1'b0;
      else if (state == S_PLAY && tone_edge) buzz <= ~buzz;
    end
  end

  assign rom_addr_o = addr;
  assign rom_en_o   = (state == S_FETCH);
  assign buzzer_o   = buzz;
  assign playing_o  = (state != S_IDLE);
  assign done_o     = (state == S_END);

endmodule
